// File: rtl/spi_byte_master.sv
// Avalon-MM SPI master (mode 0, MSB first): one byte per TXDATA write, with status
// register, overrun flag and completion interrupt. ss_n also follows the external cs_hold.
module spi_byte_master #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] address,
   input  logic       chipselect,
   input  logic       write_n,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   input  logic       cs_hold,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic       ss_n,
   output logic       irq
);

   typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state, state_next;
   logic [7:0] div_cnt;
   logic [3:0] half_cnt;
   logic [7:0] shift_reg;
   logic       miso_bit;
   logic [7:0] rx_data;
   logic       done, overrun, ie;
   logic       busy, tick, load, finish;
   logic       wr, tx_write, status_write, ie_write;

   assign busy         = (state != IDLE);
   assign wr           = chipselect & ~write_n;
   assign tx_write     = wr && (address == 2'd0);
   assign status_write = wr && (address == 2'd1);
   assign ie_write     = wr && (address == 2'd2);
   assign tick         = (div_cnt == DIV_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      finish     = 1'b0;
      unique case (state)
         IDLE: begin
            if (tx_write) begin
               state_next = SHIFT;
               load       = 1'b1;
            end
         end
         SHIFT: if (tick && half_cnt == 4'd15) state_next = TRAIL;
         TRAIL: begin
            if (tick) begin
               state_next = IDLE;
               finish     = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Rising edge captures miso; falling edge shifts it in, so mosi keeps the MSB for a full period.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt   <= '0;
         half_cnt  <= '0;
         shift_reg <= '0;
         miso_bit  <= 1'b0;
         sclk      <= 1'b0;
      end else if (load) begin
         div_cnt   <= '0;
         half_cnt  <= '0;
         shift_reg <= writedata;
         sclk      <= 1'b0;
      end else if (busy) begin
         div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
         if (state == SHIFT && tick) begin
            sclk     <= ~sclk;
            half_cnt <= half_cnt + 4'd1;
            if (!sclk) miso_bit  <= miso;
            else       shift_reg <= {shift_reg[6:0], miso_bit};
         end
      end
   end

   // Completion set takes priority over a coincident status clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data <= '0;
         done    <= 1'b0;
         overrun <= 1'b0;
         ie      <= 1'b0;
      end else begin
         if (finish) begin
            done    <= 1'b1;
            rx_data <= shift_reg;
         end else if (status_write) begin
            done <= 1'b0;
         end
         if (tx_write && busy)  overrun <= 1'b1;
         else if (status_write) overrun <= 1'b0;
         if (ie_write) ie <= writedata[0];
      end
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         2'd0:    readdata = rx_data;
         2'd1:    readdata = {5'b0, overrun, done, busy};
         2'd2:    readdata = {7'b0, ie};
         default: readdata = '0;
      endcase
   end

   assign mosi = busy & shift_reg[7];
   assign ss_n = ~(busy | cs_hold);
   assign irq  = done & ie;

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench for spi_byte_master: expected RX bytes are queued when a transfer
// is launched and popped when busy falls; a small register model predicts status and irq.
module tb_spi_byte_master;

   localparam int D    = 2;
   localparam int FALL = 1 + 17 * D;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] address = 2'd1;
   logic       chipselect = 1'b0;
   logic       write_n = 1'b1;
   logic [7:0] writedata = 8'h00;
   logic [7:0] readdata;
   logic       cs_hold = 1'b0;
   logic       miso;
   logic       sclk, mosi, ss_n, irq;

   logic loopback = 1'b1;
   logic miso_level = 1'b0;
   assign miso = loopback ? mosi : miso_level;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic m_done = 1'b0, m_overrun = 1'b0, m_ie = 1'b0;
   logic [7:0] rx_q[$];

   always #5 clk = ~clk;

   spi_byte_master #(.CLK_DIV(D)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .cs_hold(cs_hold),
      .miso(miso), .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .irq(irq)
   );

   task automatic bus_idle();
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd1;
      writedata  = 8'h00;
   endtask

   task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      bus_idle();
   endtask

   // Launch one transfer and follow it cycle by cycle until busy falls.
   task automatic do_transfer(input logic [7:0] tx, input logic [7:0] exp_rx,
                              input int ovr_cyc, input logic [7:0] ovr_data, input string tag);
      logic [7:0] mosi_byte, exp_stat, got, want;
      logic       prev_sclk, exp_irq_before;
      int         rises, fall_cyc;
      bit         ss_ok, rise_ok, irq_ok, found;
      mosi_byte = '0; prev_sclk = 1'b0; rises = 0; fall_cyc = -1;
      ss_ok = 1; rise_ok = 1; irq_ok = 1; found = 0;
      @(negedge clk); #1;
      total_cnt++;
      if (ss_n !== ~cs_hold) $display("FAIL %s idle_ss_n: got %b want %b", tag, ss_n, ~cs_hold);
      else pass_cnt++;
      exp_irq_before = m_done & m_ie;
      address = 2'd0; writedata = tx; chipselect = 1'b1; write_n = 1'b0;
      rx_q.push_back(exp_rx);
      @(posedge clk);
      for (int c = 1; c <= FALL + 10; c++) begin
         @(negedge clk);
         bus_idle();
         #1;
         if (readdata[0] === 1'b0) begin
            fall_cyc = c;
            found    = 1;
            break;
         end
         if (ss_n !== 1'b0) ss_ok = 0;
         if (irq !== exp_irq_before) irq_ok = 0;
         if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            if (c != 1 + (2 * rises + 1) * D) rise_ok = 0;
            mosi_byte = {mosi_byte[6:0], mosi};
            rises++;
         end
         prev_sclk = sclk;
         if (c == ovr_cyc) begin
            address = 2'd0; writedata = ovr_data; chipselect = 1'b1; write_n = 1'b0;
            m_overrun = 1'b1;
         end
      end
      total_cnt++;
      if (!found || fall_cyc != FALL) $display("FAIL %s busy_fall_cycle: got %0d want %0d", tag, fall_cyc, FALL);
      else pass_cnt++;
      total_cnt++;
      if (!ss_ok) $display("FAIL %s ss_n_low_while_busy: got high want low", tag);
      else pass_cnt++;
      total_cnt++;
      if (rises != 8) $display("FAIL %s sclk_rise_count: got %0d want 8", tag, rises);
      else pass_cnt++;
      total_cnt++;
      if (!rise_ok) $display("FAIL %s sclk_rise_timing: got off-schedule want 1+(2k+1)*%0d", tag, D);
      else pass_cnt++;
      total_cnt++;
      if (mosi_byte !== tx) $display("FAIL %s mosi_bits: got %h want %h", tag, mosi_byte, tx);
      else pass_cnt++;
      total_cnt++;
      if (!irq_ok) $display("FAIL %s irq_during_transfer: got change want %b", tag, exp_irq_before);
      else pass_cnt++;
      want = rx_q.pop_front();
      if (found) begin
         m_done   = 1'b1;
         exp_stat = {5'b0, m_overrun, 1'b1, 1'b0};
         total_cnt++;
         if (readdata !== exp_stat) $display("FAIL %s status: got %h want %h", tag, readdata, exp_stat);
         else pass_cnt++;
         total_cnt++;
         if (irq !== m_ie) $display("FAIL %s irq_at_done: got %b want %b", tag, irq, m_ie);
         else pass_cnt++;
         total_cnt++;
         if (ss_n !== ~cs_hold) $display("FAIL %s ss_n_at_done: got %b want %b", tag, ss_n, ~cs_hold);
         else pass_cnt++;
         address = 2'd0;
         #1;
         got = readdata;
         total_cnt++;
         if (got !== want) $display("FAIL %s rxdata: got %h want %h", tag, got, want);
         else pass_cnt++;
         address = 2'd1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; cs_hold = 1'b0; bus_idle();
      repeat (3) @(negedge clk);
      #1;
      total_cnt++;
      if (ss_n !== 1'b1) $display("FAIL reset_ss_n: got %b want 1", ss_n); else pass_cnt++;
      total_cnt++;
      if (sclk !== 1'b0 || mosi !== 1'b0) $display("FAIL reset_sclk_mosi: got %b%b want 00", sclk, mosi); else pass_cnt++;
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else pass_cnt++;
      total_cnt++;
      if (readdata !== 8'h00) $display("FAIL reset_status: got %h want 00", readdata); else pass_cnt++;
      address = 2'd0; #1;
      total_cnt++;
      if (readdata !== 8'h00) $display("FAIL reset_rxdata: got %h want 00", readdata); else pass_cnt++;
      address = 2'd2; #1;
      total_cnt++;
      if (readdata !== 8'h00) $display("FAIL reset_ie: got %h want 00", readdata); else pass_cnt++;
      address = 2'd1; cs_hold = 1'b1; #1;
      total_cnt++;
      if (ss_n !== 1'b0) $display("FAIL reset_cs_hold_ss_n: got %b want 0", ss_n); else pass_cnt++;
      cs_hold = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      m_done = 1'b0; m_overrun = 1'b0; m_ie = 1'b0;
   endtask

   task automatic test_loopback();
      loopback = 1'b1;
      do_transfer(8'hA5, 8'hA5, -1, 8'h00, "loopback");
      reg_write(2'd3, 8'hFF);
      address = 2'd3; #1;
      total_cnt++;
      if (readdata !== 8'h00) $display("FAIL addr3_read: got %h want 00", readdata); else pass_cnt++;
      address = 2'd2; #1;
      total_cnt++;
      if (readdata !== 8'h00) $display("FAIL addr3_write_ignored: got %h want 00", readdata); else pass_cnt++;
      address = 2'd1;
   endtask

   task automatic test_overrun();
      reg_write(2'd1, 8'h00);
      m_done = 1'b0; m_overrun = 1'b0;
      do_transfer(8'h3C, 8'h3C, 10, 8'hFF, "overrun");
      reg_write(2'd1, 8'h00);
      m_done = 1'b0; m_overrun = 1'b0;
      #1;
      total_cnt++;
      if (readdata !== 8'h00) $display("FAIL overrun_clear: got %h want 00", readdata); else pass_cnt++;
      do_transfer(8'h5A, 8'h5A, FALL - 1, 8'hFF, "overrun_at_completion");
      @(negedge clk); #1;
      total_cnt++;
      if (readdata !== 8'h06) $display("FAIL completion_write_ignored: got %h want 06", readdata); else pass_cnt++;
      reg_write(2'd1, 8'h00);
      m_done = 1'b0; m_overrun = 1'b0;
   endtask

   task automatic test_irq();
      reg_write(2'd2, 8'h01);
      m_ie = 1'b1;
      address = 2'd2; #1;
      total_cnt++;
      if (readdata !== 8'h01) $display("FAIL ie_readback: got %h want 01", readdata); else pass_cnt++;
      address = 2'd1;
      loopback = 1'b0; miso_level = 1'b1;
      do_transfer(8'h00, 8'hFF, -1, 8'h00, "irq");
      reg_write(2'd1, 8'h00);
      m_done = 1'b0;
      #1;
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq); else pass_cnt++;
      reg_write(2'd2, 8'h00);
      m_ie = 1'b0;
      loopback = 1'b1; miso_level = 1'b0;
   endtask

   task automatic test_back_to_back();
      cs_hold = 1'b1;
      do_transfer(8'hC3, 8'hC3, -1, 8'h00, "frame0");
      do_transfer(8'h5A, 8'h5A, -1, 8'h00, "frame1");
      @(negedge clk);
      cs_hold = 1'b0; #1;
      total_cnt++;
      if (ss_n !== 1'b1) $display("FAIL cs_hold_release: got %b want 1", ss_n); else pass_cnt++;
   endtask

   task automatic test_abort();
      reg_write(2'd1, 8'h00);
      m_done = 1'b0; m_overrun = 1'b0;
      @(negedge clk);
      address = 2'd0; writedata = 8'h96; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         bus_idle();
      end
      #1;
      total_cnt++;
      if (sclk !== 1'b1) $display("FAIL abort_pre_sclk: got %b want 1", sclk); else pass_cnt++;
      reset_n = 1'b0; #1;
      total_cnt++;
      if (sclk !== 1'b0 || mosi !== 1'b0) $display("FAIL abort_sclk_mosi: got %b%b want 00", sclk, mosi); else pass_cnt++;
      total_cnt++;
      if (readdata !== 8'h00) $display("FAIL abort_status: got %h want 00", readdata); else pass_cnt++;
      address = 2'd0; #1;
      total_cnt++;
      if (readdata !== 8'h00) $display("FAIL abort_rxdata: got %h want 00", readdata); else pass_cnt++;
      address = 2'd1;
      @(negedge clk);
      reset_n = 1'b1;
      m_done = 1'b0; m_overrun = 1'b0; m_ie = 1'b0;
      do_transfer(8'h81, 8'h81, -1, 8'h00, "abort_recover");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_loopback();
      test_overrun();
      test_irq();
      test_back_to_back();
      test_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/spi_byte_master.md
# spi_byte_master

Avalon-MM slave SPI master that shifts one byte per CPU write, used on the robot core board to talk to the radio/peripheral chip. It sits directly downstream of the single-bit chip-select PIO: that PIO's output drives `cs_hold`, which keeps the slave selected across multi-byte frames. This block generates SCLK/MOSI, samples MISO and reports completion through a status register and an interrupt.

## Interface
Parameters:
- `CLK_DIV`, default 2: SCLK half-period in clk cycles; legal range 1..255.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low; clock `clk`.
- `address`  in  2  Avalon register select.
- `chipselect`  in  1  Avalon slave select.
- `write_n`  in  1  Avalon write strobe, active-low.
- `writedata`  in  8  Avalon write data.
- `readdata`  out  8  Avalon read data, combinational, zero wait states.
- `cs_hold`  in  1  from chip-select PIO; 1 forces `ss_n` low while idle.
- `miso`  in  1  serial data from slave.
- `sclk`  out  1  SPI clock, mode 0 (idle low).
- `mosi`  out  1  serial data to slave, MSB first.
- `ss_n`  out  1  slave select, active-low, `= ~(busy | cs_hold)`.
- `irq`  out  1  `done & ie`.

## Operation
- Write strobe means `chipselect & ~write_n`.
- Register map:
  - addr 0: write = TXDATA; read = RXDATA.
  - addr 1: read = {5'b0, overrun, done, busy}; any write clears `done` and `overrun`.
  - addr 2: read/write = {7'b0, ie}.
  - addr 3: reads 0, writes ignored.
- Reads have no side effects.
- TXDATA write while idle loads the shift register and sets `busy`. TXDATA write while `busy` is ignored and sets `overrun`.
- FSM states:
  - IDLE: `sclk`=0, `mosi`=0.
  - SHIFT: 16 half-periods; `sclk` toggles every `CLK_DIV` cycles, starting low.
  - TRAIL: one half-period with `sclk`=0, then return to IDLE.
- `mosi` holds current MSB. At each SCLK rising edge, `miso` is captured into the LSB. At each falling edge, the register shifts left.
- On leaving TRAIL: `busy`←0, `done`←1, RXDATA←captured byte.
- Simultaneous events:
  - Status-clear write in the same cycle `done` is set: set wins.
  - TXDATA write in the completion cycle (`busy` still 1): ignored and counts as overrun.
- `cs_hold` changes during a transfer do not affect shifting; `ss_n` stays low until `busy` falls.
- Reset values: `sclk`=0, `mosi`=0, `ss_n`=`~cs_hold`, `irq`=0; `busy`, `done`, `overrun`, `ie` = 0; RXDATA=0x00.
- Reset mid-transfer aborts immediately to these values. No partial RXDATA update.

## Timing
- The TXDATA write is sampled at edge 0. `busy`=1 and `ss_n`=0 from cycle 1; `mosi`=bit7 from cycle 1.
- SCLK rising edge k (k=0..7) occurs at cycle `1+(2k+1)*CLK_DIV`. The matching falling edge occurs at `1+(2k+2)*CLK_DIV`.
- `busy` falls and `done`/`irq` rise at cycle `1+17*CLK_DIV`. For `CLK_DIV`=2 that is cycle 35.
- Back-to-back: the next TXDATA write is accepted the cycle after `busy` reads 0.
- `readdata` reflects register state in the same cycle as `address`.

## Test plan
- Reset: hold `reset_n`=0, `cs_hold`=0 → `ss_n`=1, `sclk`=0, `readdata` at addr1 = 0x00.
- Loopback (`miso`=`mosi`), `CLK_DIV`=2, write 0xA5:
  - `ss_n` low during cycles 1..34, exactly 8 `sclk` rising edges, `mosi` bit sequence 1,0,1,0,0,1,0,1.
  - At cycle 35: addr0 reads 0xA5 and addr1 reads 0x02.
- Overrun: write 0x3C, then write 0xFF at cycle 10 → transmitted byte stays 0x3C; status reads 0x06 after completion; a write to addr1 clears it to 0x00.
- IRQ: write addr2=1, transfer 0x00 with `miso`=1 → `irq` rises at cycle 35 and RXDATA=0xFF; a write to addr1 drops `irq` next cycle.
- Frame hold: `cs_hold`=1, two back-to-back transfers → `ss_n` stays 0 throughout; clearing `cs_hold` while idle sets `ss_n`=1 in the same cycle.
- Abort: assert `reset_n`=0 at cycle 12 of a transfer → `sclk`=0, `busy`=0, RXDATA=0x00 immediately; a fresh 0x81 transfer completes normally.
